// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: sequencer states and PC constants.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PENDING = 2'd2
    } seq_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          WORD_SHIFT       = 2;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target selection (Jr > Jump > Branch), target arithmetic and JR alignment check.
module pc_target_calc
    import mips_pkg::*;
(
    input  logic        branch_valid_i,
    input  logic        branch_taken_i,
    input  logic        jump_valid_i,
    input  logic        jr_valid_i,
    input  logic [31:0] pc_plus4_id_i,
    input  logic [31:0] imm_ext_id_i,
    input  logic [25:0] jump_index_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] target_o,
    output logic        req_o,
    output logic        misalign_o
);

    always_comb begin
        target_o   = '0;
        req_o      = 1'b0;
        misalign_o = 1'b0;
        if (jr_valid_i) begin
            target_o   = {jr_target_i[31:2], 2'b00};
            req_o      = 1'b1;
            misalign_o = |jr_target_i[1:0];
        end else if (jump_valid_i) begin
            target_o = {pc_plus4_id_i[31:28], jump_index_i, 2'b00};
            req_o    = 1'b1;
        end else if (branch_valid_i && branch_taken_i) begin
            // Offset is in words; the add wraps modulo 2^32.
            target_o = pc_plus4_id_i + (imm_ext_id_i << WORD_SHIFT);
            req_o    = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-PC controller: sequential fetch, redirects, stalls and IF/ID flush.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the delay-slot instruction (FlushIFID tied 0).
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             BranchValid,
    input  logic             BranchTaken,
    input  logic             JumpValid,
    input  logic             JrValid,
    input  logic [31:0]      PCPlus4ID,
    input  logic [31:0]      ImmExtID,
    input  logic [25:0]      JumpIndex,
    input  logic [31:0]      JrTarget,
    output logic [31:0]      PC,
    output logic [31:0]      PCPlus4,
    output logic             FetchValid,
    output logic             FlushIFID,
    output logic             AlignErr,
    output logic [CNT_W-1:0] RedirectCount,
    output logic [1:0]       DbgState
);

    seq_state_e       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pend_q, pend_d;
    logic             align_q, align_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]      target;
    logic             req;
    logic             misalign;
    logic             redirect_apply;

    pc_target_calc u_target_calc (
        .branch_valid_i (BranchValid),
        .branch_taken_i (BranchTaken),
        .jump_valid_i   (JumpValid),
        .jr_valid_i     (JrValid),
        .pc_plus4_id_i  (PCPlus4ID),
        .imm_ext_id_i   (ImmExtID),
        .jump_index_i   (JumpIndex),
        .jr_target_i    (JrTarget),
        .target_o       (target),
        .req_o          (req),
        .misalign_o     (misalign)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            align_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            align_q <= align_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pend_d         = pend_q;
        align_d        = align_q;
        cnt_d          = cnt_q;
        redirect_apply = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (req) begin
                    if (misalign) begin
                        align_d = 1'b1;
                    end
                    // A redirect during a stall is parked, never dropped.
                    if (Stall) begin
                        pend_d  = target;
                        state_d = ST_PENDING;
                    end else begin
                        pc_d           = target;
                        redirect_apply = 1'b1;
                    end
                end else if (!Stall) begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            ST_PENDING: begin
                if (!Stall) begin
                    pc_d           = pend_q;
                    redirect_apply = 1'b1;
                    state_d        = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        if (redirect_apply && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign PC            = pc_q;
    assign PCPlus4       = pc_q + PC_STEP;
    assign FetchValid    = (state_q != ST_BOOT);
    assign AlignErr      = align_q;
    assign RedirectCount = cnt_q;
    assign DbgState      = state_q;

`ifdef BRANCH_DELAY_SLOT_EN
    assign FlushIFID = 1'b0;
`else
    assign FlushIFID = redirect_apply && !Reset;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-PC controller for the pipelined MIPS core. Owns the program counter register and sequences every PC update: sequential fetch, taken branch, jump and jump-register redirects, hazard stalls, and IF/ID flushes. Branch targets are resolved in ID as PCPlus4 + (ImmExt × 4). Redirects that arrive during a stall are buffered until the pipeline can take them.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the redirect counter.

Ports:
- Clk  in  1  core clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Stall  in  1  hazard-unit hold; PC must not advance.
- BranchValid  in  1  ID holds a conditional branch; single-cycle pulse.
- BranchTaken  in  1  branch condition; qualified by BranchValid.
- JumpValid  in  1  ID holds J/JAL; pulse.
- JrValid  in  1  ID holds JR; pulse.
- PCPlus4ID  in  32  PC+4 of the ID-stage instruction.
- ImmExtID  in  32  sign-extended branch offset, in words.
- JumpIndex  in  26  J-format index field.
- JrTarget  in  32  register-sourced target.
- PC  out  32  current fetch address.
- PCPlus4  out  32  PC + 4, combinational.
- FetchValid  out  1  IF output is a real instruction.
- FlushIFID  out  1  squash the IF/ID register at this edge.
- AlignErr  out  1  sticky flag: a JrTarget had nonzero bits [1:0].
- RedirectCount  out  CNT_W  number of applied redirects, saturating.

## Operation
- States: BOOT, RUN, PENDING.
- Target selection: priority Jr > Jump > Branch.
  - Jr: {JrTarget[31:2], 2'b00}; sets AlignErr if JrTarget[1:0] != 0.
  - Jump: {PCPlus4ID[31:28], JumpIndex, 2'b00}.
  - Branch (BranchValid && BranchTaken): PCPlus4ID + (ImmExtID << 2), mod 2^32.
- A request is any of JrValid, JumpValid, or BranchValid&&BranchTaken.
- BOOT: PC = RESET_PC, FetchValid = 0, requests ignored; next cycle goes to RUN.
- RUN:
  - No request, Stall=0: PC <= PC+4, wrapping 32'hFFFF_FFFC -> 0.
  - No request, Stall=1: PC holds.
  - Request, Stall=0: PC <= target, RedirectCount++, FlushIFID asserted this cycle.
  - Request, Stall=1: latch target into PendTarget, PC holds, go to PENDING, no flush yet.
- PENDING:
  - PC holds while Stall=1. New requests are ignored.
  - When Stall=0: PC <= PendTarget, FlushIFID=1, RedirectCount++, go to RUN.
- FlushIFID is combinational from registered state and current inputs, and is forced 0 in BOOT and while Reset is high.
- RedirectCount saturates at all-ones.
- AlignErr clears only on reset.

## Timing
- Reset values: PC=RESET_PC, FetchValid=0, FlushIFID=0, AlignErr=0, RedirectCount=0, state=BOOT, PendTarget=0.
- Reset asserted mid-operation clears all state immediately, including any pending redirect.
- Redirect latency: request at cycle n with Stall=0 gives PC=target at n+1.
- Stalled redirect: the target appears on the first edge after Stall falls.
- FetchValid goes to 1 one cycle after Reset deasserts (BOOT lasts one cycle).
- Simultaneous Stall and redirect in RUN: buffer the redirect; never drop it.

## Configuration
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined: MIPS delay-slot semantics. The instruction in IF when a redirect is applied is kept, so FlushIFID is tied 0. PC still updates per the rules above.
- Undefined: FlushIFID behaves as described in Operation, squashing the wrong-path instruction.

## Structure
- Shared package mips_pkg holds:
  - the state enum (BOOT/RUN/PENDING),
  - the PC_STEP=4 constant,
  - the default RESET_PC,
  - the 2-bit word-shift constant.
- One combinational sub-module, pc_target_calc: implements priority select, target arithmetic, and alignment check; outputs the target plus a request flag.
- The state machine, PC, pending target, and counters live in pc_sequencer.

## Test plan
- Reset then release: PC=0 and FetchValid=0 for one cycle, then PC steps 0, 4, 8.
- Taken branch, Stall=0, PCPlus4ID=0x100, ImmExtID=0xFFFF_FFFC: next PC=0xF0, FlushIFID=1 (0 with BRANCH_DELAY_SLOT_EN), RedirectCount=1.
- Jump with PCPlus4ID=0x4000_0010, JumpIndex=0x0000_040: next PC=0x4000_0100.
- JrTarget=0x0000_2003 during Stall=1 for 3 cycles: PC held; then PC=0x2000 after Stall falls, AlignErr=1, one flush pulse.
- PC=0xFFFF_FFFC, no request: next PC=0. Force RedirectCount to all-ones, apply a redirect: count stays all-ones.
- Reset asserted while in PENDING: PC=RESET_PC immediately; the pending target is never applied after release.
